// File: rtl/mac_pkg.sv
// Shared constants and types for the dot-product scheduler and its MAC.
package mac_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_LEN_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_FEED  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic ID0 = 1'b0;
  localparam logic ID1 = 1'b1;

endpackage

// File: rtl/mac_acc.sv
// Unsigned multiply-accumulate register with synchronous clear.
module mac_acc #(
  parameter int DATA_W = 4,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;

  assign prod = a * b;

  // Sum wraps modulo 2**ACC_W; there is deliberately no saturation.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/mac_dot_scheduler.sv
// Round-robin scheduler sharing one MAC between two dot-product requesters.
module mac_dot_scheduler
  import mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [LEN_W-1:0]  len0,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic              valid0,
  output logic              ready0,
  input  logic              req1,
  input  logic [LEN_W-1:0]  len1,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  input  logic              valid1,
  output logic              ready1,
  output logic              busy,
  output logic [ACC_W-1:0]  result,
  output logic              result_id,
  output logic              result_valid,
  output state_t            dbg_state
);

  // Handshake: readyN depends only on state and owner, never on validN;
  // a pair transfers on a rising edge where validN && readyN.

  state_t             state, state_nx;
  logic               owner, last_owner;
  logic [LEN_W-1:0]   len_q, cnt;
  logic [ACC_W-1:0]   acc, result_q;
  logic               result_id_q;
  logic               grant_any, grant_id;
  logic [LEN_W-1:0]   grant_len;
  logic               valid_own, fire, last_pair;
  logic               clr, en;
  logic [DATA_W-1:0]  mac_a, mac_b;

  // Contention goes to whoever was not served last.
  always_comb begin
    grant_any = req0 | req1;
    grant_id  = ID0;
    if (req0 && req1) begin
      grant_id = ~last_owner;
    end else if (req1) begin
      grant_id = ID1;
    end
    grant_len = (grant_id == ID1) ? len1 : len0;
  end

  assign valid_own = (owner == ID1) ? valid1 : valid0;
  assign fire      = (state == ST_FEED) && valid_own;
  assign last_pair = (cnt == len_q - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (grant_any) begin
          state_nx = (grant_len == '0) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: state_nx = ST_FEED;
      ST_FEED: begin
        if (fire && last_pair) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ready0       = (state == ST_FEED) && (owner == ID0);
    ready1       = (state == ST_FEED) && (owner == ID1);
    busy         = (state != ST_IDLE);
    result_valid = (state == ST_DONE);
    // An empty job clears at grant so DONE reports zero.
    clr          = (state == ST_CLEAR) ||
                   ((state == ST_IDLE) && grant_any && (grant_len == '0));
    en           = fire;
    mac_a        = (owner == ID1) ? a1 : a0;
    mac_b        = (owner == ID1) ? b1 : b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= ID0;
      last_owner  <= ID1;
      len_q       <= '0;
      cnt         <= '0;
      result_q    <= '0;
      result_id_q <= ID0;
    end else begin
      if ((state == ST_IDLE) && grant_any) begin
        owner <= grant_id;
        len_q <= grant_len;
      end
      if (state == ST_CLEAR) begin
        cnt <= '0;
      end else if (fire) begin
        cnt <= cnt + LEN_W'(1);
      end
      if (state == ST_DONE) begin
        result_q    <= acc;
        result_id_q <= owner;
        last_owner  <= owner;
      end
    end
  end

  // acc is stable in DONE, so the result is visible during the pulse itself.
  assign result    = (state == ST_DONE) ? acc : result_q;
  assign result_id = (state == ST_DONE) ? owner : result_id_q;
  assign dbg_state = state;

  mac_acc #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en (en),
    .a  (mac_a),
    .b  (mac_b),
    .acc(acc)
  );

endmodule

// File: tb/tb_mac_dot_scheduler.sv
// Bench for mac_dot_scheduler: vector table, corner sequences, random jobs vs. dot-product model.
module tb_mac_dot_scheduler;
  import mac_pkg::*;

  localparam int TIMEOUT = 400;

  logic        clk, rst;
  logic        req0, valid0, ready0, req1, valid1, ready1;
  logic [3:0]  len0, a0, b0, len1, a1, b1;
  logic        busy, result_id, result_valid;
  logic [15:0] result;
  state_t      dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  bit fin[2];
  int pulse_cyc[2];
  logic model_last;
  logic [16:0] exp_q[$];

  typedef struct {
    int          id;
    int          len;
    logic [63:0] a_pk;
    logic [63:0] b_pk;
    int          gap;
    logic [15:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t tbl[6];

  mac_dot_scheduler dut (
    .clk(clk), .rst(rst),
    .req0(req0), .len0(len0), .a0(a0), .b0(b0), .valid0(valid0), .ready0(ready0),
    .req1(req1), .len1(len1), .a1(a1), .b1(b1), .valid1(valid1), .ready1(ready1),
    .busy(busy), .result(result), .result_id(result_id), .result_valid(result_valid),
    .dbg_state(dbg_state)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] dot(input int len, input logic [63:0] a, input logic [63:0] b);
    int s;
    s = 0;
    for (int i = 0; i < len; i++) s += int'(a[4*i+:4]) * int'(b[4*i+:4]);
    return s[15:0];
  endfunction

  task automatic drive(input int id, input logic rq, input logic [3:0] ln,
                       input logic v, input logic [3:0] a, input logic [3:0] b);
    if (id == 0) begin
      req0 = rq; len0 = ln; valid0 = v; a0 = a; b0 = b;
    end else begin
      req1 = rq; len1 = ln; valid1 = v; a1 = a; b1 = b;
    end
  endtask

  // Producer for one job; call at a negedge. Pops and checks the scoreboard on its own pulse.
  task automatic run_job(input int id, input int len, input logic [63:0] a_pk,
                         input logic [63:0] b_pk, input int gap, output int lat);
    int idx, g, cyc;
    bit done, bad_ready;
    logic own_ready;
    logic [3:0] ln;
    logic [15:0] got_res;
    logic got_id;
    logic [16:0] exp_e;
    idx = 0; g = 0; cyc = 0; done = 0; bad_ready = 0; lat = -1;
    while (!done && cyc < TIMEOUT) begin
      if (result_valid && (result_id == id[0])) begin
        done = 1;
        lat = cyc;
      end else begin
        own_ready = (id == 0) ? ready0 : ready1;
        if (ready0 && ready1) bad_ready = 1;
        if (own_ready && idx >= len) bad_ready = 1;
        ln = (idx == 0) ? len[3:0] : 4'($urandom_range(0, 15));
        if (idx < len && g == 0) begin
          drive(id, 1'b1, ln, 1'b1, a_pk[4*idx+:4], b_pk[4*idx+:4]);
          if (own_ready) begin
            idx++;
            g = gap;
          end
        end else begin
          drive(id, 1'b1, ln, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
          if (g > 0) g--;
        end
        @(negedge clk);
        cyc++;
      end
    end
    drive(id, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
    fin[id] = 1;
    pulse_cyc[id] = cyc_cnt;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL job_timeout: requester %0d got no result within %0d cycles", id, TIMEOUT);
    end else begin
      got_res = result;
      got_id  = result_id;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got %0d id %0d, expected none", got_res, got_id);
      end else begin
        exp_e = exp_q.pop_front();
        chk("result", 32'(got_res), 32'(exp_e[15:0]));
        chk("result_id", 32'(got_id), 32'(exp_e[16]));
      end
      chk("ready_rules", 32'(bad_ready), 32'd0);
      @(negedge clk);
      chk("pulse_width", 32'(result_valid), 32'd0);
      chk("result_hold", 32'(result), 32'(got_res));
    end
  endtask

  initial begin
    int lat_a, lat_b;
    drive(0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
    drive(1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
    rst = 1;
    model_last = 1'b1;

    tbl[0] = '{0, 3,  64'h123,             64'h154,             0, 16'd23,   5};
    tbl[1] = '{1, 2,  64'h17,              64'h97,              3, 16'd58,   7};
    tbl[2] = '{0, 0,  64'h0,               64'h0,               0, 16'd0,    1};
    tbl[3] = '{1, 1,  64'hF,               64'hF,               0, 16'd225,  3};
    tbl[4] = '{0, 15, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 16'd3375, 17};
    tbl[5] = '{1, 4,  64'h18F0,            64'h280F,            1, 16'd66,   9};

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready0", 32'(ready0), 32'd0);
    chk("rst_ready1", 32'(ready1), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_result_id", 32'(result_id), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 0;

    // Both requesting straight out of reset: requester 0 first.
    exp_q.push_back({1'b0, 16'd225});
    exp_q.push_back({1'b1, 16'd6});
    fork
      run_job(0, 1, 64'hF, 64'hF, 0, lat_a);
      run_job(1, 1, 64'h2, 64'h3, 0, lat_b);
    join
    model_last = 1'b1;

    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({tbl[i].id[0], tbl[i].exp_res});
      run_job(tbl[i].id, tbl[i].len, tbl[i].a_pk, tbl[i].b_pk, tbl[i].gap, lat_a);
      if (tbl[i].exp_lat >= 0) chk("latency", 32'(lat_a), 32'(tbl[i].exp_lat));
      model_last = tbl[i].id[0];
    end

    // Requester 1 arrives mid-job and must wait for requester 0 to finish.
    fin[0] = 0;
    fin[1] = 0;
    exp_q.push_back({1'b0, 16'd3375});
    exp_q.push_back({1'b1, 16'd39});
    fork
      run_job(0, 15, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, lat_a);
      begin
        repeat (5) @(negedge clk);
        run_job(1, 2, 64'h35, 64'h36, 0, lat_b);
      end
      begin
        int k;
        bit seen;
        k = 0;
        seen = 0;
        while (!fin[0] && k < 300) begin
          @(negedge clk);
          if (ready1 && !fin[0]) seen = 1;
          k++;
        end
        chk("ready1_early", 32'(seen), 32'd0);
        while (cyc_cnt < pulse_cyc[0] + 2 && k < 600) begin
          @(negedge clk);
          k++;
        end
        chk("req1_grant_next_idle", 32'(dbg_state), 32'(ST_CLEAR));
      end
    join
    model_last = 1'b1;

    // Reset in the middle of a job: no pulse, everything back to idle.
    req0 = 1; len0 = 4'd5; valid0 = 1; a0 = 4'd15; b0 = 4'd15;
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready0", 32'(ready0), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_result_id", 32'(result_id), 32'd0);
    chk("midrst_result_valid", 32'(result_valid), 32'd0);
    req0 = 0; valid0 = 0; rst = 0;
    model_last = 1'b1;
    @(negedge clk);
    chk("midrst_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("midrst_no_pulse", 32'(result_valid), 32'd0);

    // Random jobs against the arithmetic model.
    for (int r = 0; r < 30; r++) begin
      int mode, l0, l1, g0, g1;
      logic [63:0] pa0, pb0, pa1, pb1;
      logic first;
      mode = $urandom_range(0, 2);
      l0 = $urandom_range(0, 15);
      l1 = $urandom_range(0, 15);
      g0 = $urandom_range(0, 2);
      g1 = $urandom_range(0, 2);
      for (int i = 0; i < 16; i++) begin
        pa0[4*i+:4] = 4'($urandom_range(0, 15));
        pb0[4*i+:4] = 4'($urandom_range(0, 15));
        pa1[4*i+:4] = 4'($urandom_range(0, 15));
        pb1[4*i+:4] = 4'($urandom_range(0, 15));
      end
      if (mode == 0) begin
        exp_q.push_back({1'b0, dot(l0, pa0, pb0)});
        run_job(0, l0, pa0, pb0, g0, lat_a);
        if (g0 == 0) chk("rand_latency0", 32'(lat_a), (l0 == 0) ? 32'd1 : 32'(l0 + 2));
        model_last = 1'b0;
      end else if (mode == 1) begin
        exp_q.push_back({1'b1, dot(l1, pa1, pb1)});
        run_job(1, l1, pa1, pb1, g1, lat_b);
        model_last = 1'b1;
      end else begin
        first = ~model_last;
        if (first == 1'b0) begin
          exp_q.push_back({1'b0, dot(l0, pa0, pb0)});
          exp_q.push_back({1'b1, dot(l1, pa1, pb1)});
        end else begin
          exp_q.push_back({1'b1, dot(l1, pa1, pb1)});
          exp_q.push_back({1'b0, dot(l0, pa0, pb0)});
        end
        fork
          run_job(0, l0, pa0, pb0, g0, lat_a);
          run_job(1, l1, pa1, pb1, g1, lat_b);
        join
        model_last = ~first;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
